rv32_writeback: RTL and testbench

Final (MEM→WB) pipeline stage of the RV32 core. Registers the memory-stage result, performs load byte/halfword lane selection and sign/zero extension, and drives the register file write port. It produces the `rd`, write-enable, write-data and writeback-flush signals consumed by the register file, plus a retire pulse and an optional instret counter.

---
 rtl/rv32_writeback.sv | 119 +++++++++++
 tb/tb_rv32_writeback.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/rv32_writeback.sv
// MEM->WB pipeline register with load lane extraction and register file write port.
// Optional retired-instruction counter enabled by defining RV32_WB_INSTRET_EN.
module rv32_writeback (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_in,
    input  logic        flush_in,
    input  logic        mem_valid_in,
    input  logic [4:0]  mem_rd_in,
    input  logic        mem_rd_write_in,
    input  logic [31:0] mem_result_in,
    input  logic        mem_load_in,
    input  logic [1:0]  mem_load_width_in,
    input  logic        mem_load_unsigned_in,
    input  logic [1:0]  mem_addr_low_in,
    input  logic [31:0] mem_read_value_in,
    output logic [4:0]  rd_out,
    output logic        rd_write_out,
    output logic [31:0] rd_value_out,
    output logic        writeback_flush_out,
    output logic        retire_out,
    output logic [63:0] instret_out
);

    typedef enum logic [1:0] {
        LOAD_BYTE = 2'b00,
        LOAD_HALF = 2'b01,
        LOAD_WORD = 2'b10,
        LOAD_WIDE = 2'b11
    } load_width_e;

    load_width_e load_width;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_value;
    logic [31:0] capture_value;
    logic        capture;
    logic        capture_valid;

    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        wb_rd_write;
    logic [31:0] wb_value;
    logic        wb_retire;

    assign load_width    = load_width_e'(mem_load_width_in);
    assign capture       = !stall_in;
    assign capture_valid = capture && mem_valid_in && !flush_in;

    always_comb begin
        byte_lane = mem_read_value_in[7:0];
        case (mem_addr_low_in)
            2'd0: byte_lane = mem_read_value_in[7:0];
            2'd1: byte_lane = mem_read_value_in[15:8];
            2'd2: byte_lane = mem_read_value_in[23:16];
            2'd3: byte_lane = mem_read_value_in[31:24];
            default: byte_lane = mem_read_value_in[7:0];
        endcase
    end

    // Address bit 0 is not consulted: misaligned halfword loads trap upstream.
    assign half_lane = mem_addr_low_in[1] ? mem_read_value_in[31:16]
                                          : mem_read_value_in[15:0];

    always_comb begin
        load_value = mem_read_value_in;
        case (load_width)
            LOAD_BYTE: load_value = {{24{byte_lane[7] & !mem_load_unsigned_in}}, byte_lane};
            LOAD_HALF: load_value = {{16{half_lane[15] & !mem_load_unsigned_in}}, half_lane};
            LOAD_WORD: load_value = mem_read_value_in;
            LOAD_WIDE: load_value = mem_read_value_in;
            default:   load_value = mem_read_value_in;
        endcase
    end

    assign capture_value = mem_load_in ? load_value : mem_result_in;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_valid    <= 1'b0;
            wb_rd       <= '0;
            wb_rd_write <= 1'b0;
            wb_value    <= '0;
            wb_retire   <= 1'b0;
        end else begin
            // retire fires only on the loading edge, never while a stall holds the entry
            wb_retire <= capture_valid;
            if (capture) begin
                wb_valid    <= mem_valid_in && !flush_in;
                wb_rd       <= mem_rd_in;
                wb_rd_write <= mem_rd_write_in;
                wb_value    <= capture_value;
            end
        end
    end

`ifdef RV32_WB_INSTRET_EN
    logic [63:0] instret;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instret <= '0;
        end else if (capture_valid) begin
            instret <= instret + 64'd1;
        end
    end

    assign instret_out = instret;
`else
    assign instret_out = '0;
`endif

    assign rd_out              = wb_rd;
    assign rd_value_out        = wb_value;
    assign rd_write_out        = wb_valid && wb_rd_write && (wb_rd != 5'd0);
    assign writeback_flush_out = !wb_valid;
    assign retire_out          = wb_retire;

endmodule

// File: tb/tb_rv32_writeback.sv
// Directed bench for rv32_writeback: behavioural model checked every cycle plus literal expectations.
module tb_rv32_writeback;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall_in = 1'b0;
    logic        flush_in = 1'b0;
    logic        mem_valid_in = 1'b0;
    logic [4:0]  mem_rd_in = '0;
    logic        mem_rd_write_in = 1'b0;
    logic [31:0] mem_result_in = '0;
    logic        mem_load_in = 1'b0;
    logic [1:0]  mem_load_width_in = '0;
    logic        mem_load_unsigned_in = 1'b0;
    logic [1:0]  mem_addr_low_in = '0;
    logic [31:0] mem_read_value_in = '0;
    logic [4:0]  rd_out;
    logic        rd_write_out;
    logic [31:0] rd_value_out;
    logic        writeback_flush_out;
    logic        retire_out;
    logic [63:0] instret_out;

    int unsigned n_checks = 0;
    int unsigned n_fail = 0;

    rv32_writeback dut (
        .clk                  (clk),
        .reset                (reset),
        .stall_in             (stall_in),
        .flush_in             (flush_in),
        .mem_valid_in         (mem_valid_in),
        .mem_rd_in            (mem_rd_in),
        .mem_rd_write_in      (mem_rd_write_in),
        .mem_result_in        (mem_result_in),
        .mem_load_in          (mem_load_in),
        .mem_load_width_in    (mem_load_width_in),
        .mem_load_unsigned_in (mem_load_unsigned_in),
        .mem_addr_low_in      (mem_addr_low_in),
        .mem_read_value_in    (mem_read_value_in),
        .rd_out               (rd_out),
        .rd_write_out         (rd_write_out),
        .rd_value_out         (rd_value_out),
        .writeback_flush_out  (writeback_flush_out),
        .retire_out           (retire_out),
        .instret_out          (instret_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Load data expressed as shift-and-mask arithmetic with explicit sign fill.
    function automatic logic [31:0] model_load(input logic [1:0] width, input logic uns,
                                               input logic [1:0] addr, input logic [31:0] word);
        logic [31:0] x;
        if (width == 2'd0) begin
            x = (word >> (8 * int'(addr))) & 32'h0000_00FF;
            if (!uns && x >= 32'h80) x = x | 32'hFFFF_FF00;
        end else if (width == 2'd1) begin
            x = (word >> (addr >= 2'd2 ? 16 : 0)) & 32'h0000_FFFF;
            if (!uns && x >= 32'h8000) x = x | 32'hFFFF_0000;
        end else begin
            x = word;
        end
        return x;
    endfunction

    logic        m_valid, m_rdw, m_retire;
    logic [4:0]  m_rd;
    logic [31:0] m_val;
    logic [63:0] m_retired;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid <= 1'b0; m_rd <= '0; m_rdw <= 1'b0; m_val <= '0;
            m_retire <= 1'b0; m_retired <= '0;
        end else begin
            m_retire <= 1'b0;
            if (!stall_in) begin
                m_valid <= mem_valid_in && !flush_in;
                m_rd    <= mem_rd_in;
                m_rdw   <= mem_rd_write_in;
                m_val   <= mem_load_in ? model_load(mem_load_width_in, mem_load_unsigned_in,
                                                    mem_addr_low_in, mem_read_value_in)
                                       : mem_result_in;
                if (mem_valid_in && !flush_in) begin
                    m_retire  <= 1'b1;
                    m_retired <= m_retired + 64'd1;
                end
            end
        end
    end

    function automatic logic [63:0] exp_instret(input logic [63:0] retired);
`ifdef RV32_WB_INSTRET_EN
        return retired;
`else
        return 64'd0 & retired;
`endif
    endfunction

    always @(negedge clk) begin
        chk("model_rd", {59'd0, rd_out}, {59'd0, m_rd});
        chk("model_value", {32'd0, rd_value_out}, {32'd0, m_val});
        chk("model_we", {63'd0, rd_write_out}, {63'd0, m_valid && m_rdw && (m_rd != 5'd0)});
        chk("model_bubble", {63'd0, writeback_flush_out}, {63'd0, !m_valid});
        chk("model_retire", {63'd0, retire_out}, {63'd0, m_retire});
        chk("model_instret", instret_out, exp_instret(m_retired));
    end

    task automatic apply(input logic v, input logic [4:0] rd, input logic rdw,
                         input logic [31:0] res, input logic ld, input logic [1:0] w,
                         input logic u, input logic [1:0] a, input logic [31:0] word,
                         input logic st, input logic fl);
        @(negedge clk);
        mem_valid_in = v; mem_rd_in = rd; mem_rd_write_in = rdw; mem_result_in = res;
        mem_load_in = ld; mem_load_width_in = w; mem_load_unsigned_in = u;
        mem_addr_low_in = a; mem_read_value_in = word; stall_in = st; flush_in = fl;
        @(posedge clk);
        #1;
    endtask

    logic [63:0] inst0;
    logic [63:0] one_if_en;

    initial begin
`ifdef RV32_WB_INSTRET_EN
        one_if_en = 64'd1;
`else
        one_if_en = 64'd0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_bubble", {63'd0, writeback_flush_out}, 64'd1);
        chk("rst_we", {63'd0, rd_write_out}, 64'd0);
        chk("rst_instret", instret_out, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        apply(1, 5'd1, 1, 32'h0, 1, 2'd0, 0, 2'd3, 32'h80FF_1234, 0, 0);
        chk("lb_a3", {32'd0, rd_value_out}, 64'hFFFF_FF80);
        chk("lb_a3_we", {63'd0, rd_write_out}, 64'd1);
        apply(1, 5'd2, 1, 32'h0, 1, 2'd0, 1, 2'd3, 32'h80FF_1234, 0, 0);
        chk("lbu_a3", {32'd0, rd_value_out}, 64'h0000_0080);
        apply(1, 5'd3, 1, 32'h0, 1, 2'd0, 0, 2'd1, 32'h80FF_1234, 0, 0);
        chk("lb_a1", {32'd0, rd_value_out}, 64'h0000_0012);
        apply(1, 5'd4, 1, 32'h0, 1, 2'd1, 0, 2'd2, 32'h8001_7FFF, 0, 0);
        chk("lh_a2", {32'd0, rd_value_out}, 64'hFFFF_8001);
        apply(1, 5'd4, 1, 32'h0, 1, 2'd1, 0, 2'd0, 32'h8001_7FFF, 0, 0);
        chk("lh_a0", {32'd0, rd_value_out}, 64'h0000_7FFF);
        apply(1, 5'd4, 1, 32'h0, 1, 2'd1, 1, 2'd2, 32'h8001_7FFF, 0, 0);
        chk("lhu_a2", {32'd0, rd_value_out}, 64'h0000_8001);
        apply(1, 5'd4, 1, 32'h0, 1, 2'd1, 0, 2'd3, 32'h8001_7FFF, 0, 0);
        chk("lh_a3", {32'd0, rd_value_out}, 64'hFFFF_8001);
        apply(1, 5'd6, 1, 32'h0, 1, 2'd3, 0, 2'd1, 32'hA5C3_0F96, 0, 0);
        chk("lw_w3", {32'd0, rd_value_out}, 64'hA5C3_0F96);

        inst0 = instret_out;
        apply(1, 5'd0, 1, 32'hDEAD_BEEF, 0, 2'd0, 0, 2'd0, 32'h0, 0, 0);
        chk("x0_we", {63'd0, rd_write_out}, 64'd0);
        chk("x0_retire", {63'd0, retire_out}, 64'd1);
        chk("x0_instret", instret_out - inst0, one_if_en);

        inst0 = instret_out;
        apply(1, 5'd7, 1, 32'h1357_9BDF, 0, 2'd0, 0, 2'd0, 32'h0, 0, 0);
        chk("st_retire0", {63'd0, retire_out}, 64'd1);
        for (int i = 0; i < 3; i++) begin
            apply(1, 5'(10 + i), 1, 32'h1111_0000 + 32'(i), i[0], 2'd0, 0, 2'd0,
                  32'hFFFF_FFFF, 1, i == 1);
            chk("st_rd", {59'd0, rd_out}, 64'd7);
            chk("st_value", {32'd0, rd_value_out}, 64'h1357_9BDF);
            chk("st_we", {63'd0, rd_write_out}, 64'd1);
            chk("st_retire", {63'd0, retire_out}, 64'd0);
        end
        chk("st_instret", instret_out - inst0, one_if_en);

        inst0 = instret_out;
        apply(1, 5'd9, 1, 32'h2468_ACE0, 0, 2'd0, 0, 2'd0, 32'h0, 0, 1);
        chk("fl_bubble", {63'd0, writeback_flush_out}, 64'd1);
        chk("fl_we", {63'd0, rd_write_out}, 64'd0);
        chk("fl_retire", {63'd0, retire_out}, 64'd0);
        chk("fl_instret", instret_out - inst0, 64'd0);

        apply(1, 5'd5, 1, 32'hCAFE_F00D, 0, 2'd0, 0, 2'd0, 32'h0, 0, 0);
        apply(1, 5'd8, 1, 32'h0BAD_0BAD, 0, 2'd0, 0, 2'd0, 32'h0, 1, 0);
        chk("hold_rd5", {59'd0, rd_out}, 64'd5);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_rd", {59'd0, rd_out}, 64'd0);
        chk("arst_value", {32'd0, rd_value_out}, 64'd0);
        chk("arst_we", {63'd0, rd_write_out}, 64'd0);
        chk("arst_bubble", {63'd0, writeback_flush_out}, 64'd1);
        chk("arst_retire", {63'd0, retire_out}, 64'd0);
        chk("arst_instret", instret_out, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        apply(1, 5'd12, 1, 32'h7777_8888, 0, 2'd0, 0, 2'd0, 32'h0, 0, 0);
        chk("post_rst_value", {32'd0, rd_value_out}, 64'h7777_8888);
        chk("post_rst_instret", instret_out, one_if_en);
        apply(0, 5'd0, 0, 32'h0, 0, 2'd0, 0, 2'd0, 32'h0, 0, 0);
        chk("idle_bubble", {63'd0, writeback_flush_out}, 64'd1);
        @(negedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
